// File: rtl/sag_pkg.sv
// Shared types and constants for the secure access gateway: FSM states,
// header magic, response prefix and error codes.
package sag_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEY   = 3'd1,
    ST_CHECK = 3'd2,
    ST_RESP  = 3'd3,
    ST_LOCK  = 3'd4
  } sag_state_e;

  localparam logic [7:0] MAGIC      = 8'hA5;
  localparam logic [7:0] ERR_PREFIX = 8'hEE;
  localparam logic [7:0] ERR_MAGIC  = 8'h01;
  localparam logic [7:0] ERR_KEY    = 8'h02;
  localparam logic [7:0] ERR_ACCESS = 8'h03;

endpackage

// File: rtl/sag_rsp_serializer.sv
// Response word sequencer: loads either the full private payload or a single
// error word, then presents words MSW first, advancing only on handshake.
module sag_rsp_serializer
  import sag_pkg::*;
#(
  parameter int PKT_S = 32,
  parameter int D_S   = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             grant,
  input  logic [D_S-1:0]   payload,
  input  logic [7:0]       code,
  input  logic             rd_ready,
  output logic [PKT_S-1:0] data_out,
  output logic             rsp_valid,
  output logic             done
);

  localparam int NW = D_S / PKT_S;
  localparam int CW = $clog2(NW + 1);

  logic [D_S-1:0]   sr_reg;
  logic [CW-1:0]    left_reg;
  logic             valid_reg;
  logic [PKT_S-1:0] err_word;
  logic [D_S-1:0]   err_frame;
  logic             hs;
  logic             last;

  always_comb begin
    err_word                = '0;
    err_word[PKT_S-1 -: 8]  = ERR_PREFIX;
    err_word[7:0]           = code;
    err_frame               = '0;
    err_frame[D_S-1 -: PKT_S] = err_word;
  end

  assign hs   = valid_reg && rd_ready;
  assign last = (left_reg == CW'(1));
  assign done = hs && last;

  // The outgoing word is always the top slice of the shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_reg    <= '0;
      left_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      if (grant) begin
        sr_reg   <= payload;
        left_reg <= CW'(NW);
      end else begin
        sr_reg   <= err_frame;
        left_reg <= CW'(1);
      end
    end else if (hs) begin
      if (last) begin
        valid_reg <= 1'b0;
        sr_reg    <= '0;
        left_reg  <= '0;
      end else begin
        sr_reg   <= sr_reg << PKT_S;
        left_reg <= left_reg - CW'(1);
      end
    end
  end

  assign data_out  = sr_reg[D_S-1 -: PKT_S];
  assign rsp_valid = valid_reg;

endmodule

// File: rtl/secure_access_gateway.sv
// Request/response access gateway: header + key hash in, private data or an
// error word out, with consecutive-failure lockout.
module secure_access_gateway
  import sag_pkg::*;
#(
  parameter int PKT_S    = 32,
  parameter int D_S      = 128,
  parameter int KH_S     = 64,
  parameter int DT_S     = 3,
  parameter int ACR_S    = 8,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYC = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PKT_S-1:0]                 data_in,
  input  logic                             req_valid,
  output logic                             req_ready,
  output logic [PKT_S-1:0]                 data_out,
  output logic                             rsp_valid,
  input  logic                             rd_ready,
  input  logic [(2**DT_S)*ACR_S-1:0]       access_reg,
  input  logic [KH_S-1:0]                  key_ref,
  input  logic [D_S-1:0]                   priv_data,
  output logic                             lock_active,
  output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt
);

  localparam int NT   = 2 ** DT_S;
  localparam int KW   = KH_S / PKT_S;
  localparam int KC_W = (KW > 1) ? $clog2(KW) : 1;
  localparam int FC_W = $clog2(MAX_FAIL + 1);
  localparam int TM_W = $clog2(LOCK_CYC + 1);

  if ((D_S % PKT_S) != 0 || (KH_S % PKT_S) != 0 || PKT_S < 16 || MAX_FAIL < 1) begin : g_bad_params
    $error("secure_access_gateway: illegal parameter combination");
  end

  sag_state_e       state_reg, state_next;
  logic             alive_reg;
  logic [DT_S-1:0]  type_reg;
  logic [KH_S-1:0]  key_sr_reg;
  logic [KC_W-1:0]  key_cnt_reg;
  logic [FC_W-1:0]  fail_cnt_reg;
  logic [TM_W-1:0]  timer_reg;

  logic [NT-1:0]    permit;
  logic             magic_ok;
  logic             key_ok;
  logic             chk_grant;
  logic [7:0]       chk_code;
  logic             req_hs;
  logic             key_last;
  logic             lock_due;
  logic             ser_load;
  logic             ser_grant;
  logic [7:0]       ser_code;
  logic             rsp_done;
  logic             unused_bits;

  // Only bit 0 of each access-control field carries meaning.
  for (genvar gi = 0; gi < NT; gi++) begin : g_permit
    assign permit[gi] = access_reg[gi*ACR_S];
  end

  assign unused_bits = ^{access_reg, data_in};

  assign magic_ok  = (data_in[PKT_S-1 -: 8] == MAGIC);
  assign key_ok    = (key_sr_reg == key_ref);
  assign chk_grant = key_ok && permit[type_reg];
  assign chk_code  = key_ok ? ERR_ACCESS : ERR_KEY;
  assign req_hs    = req_valid && req_ready;
  assign key_last  = (key_cnt_reg == KC_W'(KW - 1));
  assign lock_due  = (fail_cnt_reg == FC_W'(MAX_FAIL));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (req_hs) state_next = magic_ok ? ST_KEY : ST_RESP;
      ST_KEY:   if (req_hs && key_last) state_next = ST_CHECK;
      ST_CHECK: state_next = ST_RESP;
      ST_RESP:  if (rsp_done) state_next = lock_due ? ST_LOCK : ST_IDLE;
      ST_LOCK:  if (timer_reg <= TM_W'(1)) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // alive_reg holds req_ready low until the first edge after reset release.
  always_comb begin
    req_ready   = 1'b0;
    lock_active = 1'b0;
    ser_load    = 1'b0;
    ser_grant   = 1'b0;
    ser_code    = ERR_MAGIC;
    case (state_reg)
      ST_IDLE: begin
        req_ready = alive_reg;
        ser_load  = req_valid && alive_reg && !magic_ok;
      end
      ST_KEY:   req_ready = alive_reg;
      ST_CHECK: begin
        ser_load  = 1'b1;
        ser_grant = chk_grant;
        ser_code  = chk_code;
      end
      ST_LOCK:  lock_active = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive_reg    <= 1'b0;
      type_reg     <= '0;
      key_sr_reg   <= '0;
      key_cnt_reg  <= '0;
      fail_cnt_reg <= '0;
      timer_reg    <= '0;
    end else begin
      alive_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: if (req_hs && magic_ok) begin
          type_reg    <= data_in[DT_S-1:0];
          key_cnt_reg <= '0;
        end
        ST_KEY: if (req_hs) begin
          key_sr_reg  <= (key_sr_reg << PKT_S) | KH_S'(data_in);
          key_cnt_reg <= key_cnt_reg + KC_W'(1);
        end
        ST_CHECK: begin
          if (chk_grant)
            fail_cnt_reg <= '0;
          else if (fail_cnt_reg < FC_W'(MAX_FAIL))
            fail_cnt_reg <= fail_cnt_reg + FC_W'(1);
        end
        ST_RESP: if (rsp_done && lock_due) begin
          fail_cnt_reg <= '0;
          timer_reg    <= TM_W'(LOCK_CYC);
        end
        ST_LOCK: if (timer_reg != '0) timer_reg <= timer_reg - TM_W'(1);
        default: ;
      endcase
    end
  end

  assign fail_cnt = fail_cnt_reg;

  sag_rsp_serializer #(
    .PKT_S (PKT_S),
    .D_S   (D_S)
  ) u_rsp (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .grant     (ser_grant),
    .payload   (priv_data),
    .code      (ser_code),
    .rd_ready  (rd_ready),
    .data_out  (data_out),
    .rsp_valid (rsp_valid),
    .done      (rsp_done)
  );

endmodule

// File: tb/tb_secure_access_gateway.sv
// Directed bench for secure_access_gateway with default parameters.
module tb_secure_access_gateway;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  data_in = '0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  data_out;
  logic         rsp_valid;
  logic         rd_ready = 1'b1;
  logic [63:0]  access_reg = 64'h0000_0000_0001_0000;
  logic [63:0]  key_ref    = 64'h0123_4567_89AB_CDEF;
  logic [127:0] priv_data  = 128'hD0D0_0001_D0D0_0002_D0D0_0003_D0D0_0004;
  logic         lock_active;
  logic [1:0]   fail_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] K0 = 32'h0123_4567;
  localparam logic [31:0] K1 = 32'h89AB_CDEF;
  localparam logic [31:0] KBAD = 32'h89AB_CDEE;

  secure_access_gateway dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .data_out    (data_out),
    .rsp_valid   (rsp_valid),
    .rd_ready    (rd_ready),
    .access_reg  (access_reg),
    .key_ref     (key_ref),
    .priv_data   (priv_data),
    .lock_active (lock_active),
    .fail_cnt    (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input string tag, input logic [31:0] w);
    int n;
    n = 0;
    data_in   = w;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_ready"}, req_ready, 1'b1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic read_word(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    rd_ready = 1'b1;
    while (!rsp_valid && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, rsp_valid, 1'b1);
    chk({tag, "_data"}, data_out, exp);
    step();
  endtask

  // Header plus two key words; ends one cycle after CHECK with rsp_valid expected high.
  task automatic send_req(input string tag, input logic [31:0] hdr, input logic [31:0] k0, input logic [31:0] k1);
    send_word({tag, "_hdr"}, hdr);
    send_word({tag, "_k0"}, k0);
    send_word({tag, "_k1"}, k1);
    chk({tag, "_check_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_check_req_ready"}, req_ready, 1'b0);
    step();
    chk({tag, "_rsp_after_check"}, rsp_valid, 1'b1);
  endtask

  task automatic grant_req(input string tag);
    send_req(tag, 32'hA500_0002, K0, K1);
    chk({tag, "_fail_cnt"}, fail_cnt, 2'd0);
    read_word({tag, "_w0"}, 32'hD0D0_0001);
    read_word({tag, "_w1"}, 32'hD0D0_0002);
    read_word({tag, "_w2"}, 32'hD0D0_0003);
    read_word({tag, "_w3"}, 32'hD0D0_0004);
    chk({tag, "_idle_ready"}, req_ready, 1'b1);
  endtask

  task automatic err_req(input string tag, input logic [31:0] hdr, input logic [31:0] k1,
                         input logic [31:0] exp_word, input logic [1:0] exp_fail);
    send_req(tag, hdr, K0, k1);
    chk({tag, "_fail_cnt"}, fail_cnt, exp_fail);
    read_word({tag, "_err"}, exp_word);
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_data_out"}, data_out, 32'h0);
    chk({tag, "_lock"}, lock_active, 1'b0);
    chk({tag, "_fail_cnt"}, fail_cnt, 2'd0);
  endtask

  task automatic release_reset(input string tag);
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    chk({tag, "_ready_before_edge"}, req_ready, 1'b0);
    step();
    chk({tag, "_ready_after_edge"}, req_ready, 1'b1);
  endtask

  initial begin
    // Power-on reset
    step();
    step();
    reset_outputs("por");
    release_reset("por");

    grant_req("grant1");

    // Correct key, type 5 not permitted
    err_req("deny_t5", 32'hA500_0005, K1, 32'hEE00_0003, 2'd1);
    // Wrong key and type not permitted: key mismatch has priority
    err_req("both_bad", 32'hA500_0005, KBAD, 32'hEE00_0002, 2'd2);

    // Bad magic: immediate single error word, no key words, fail_cnt untouched
    send_word("magic_hdr", 32'h1200_0002);
    chk("magic_rsp_valid", rsp_valid, 1'b1);
    chk("magic_req_ready", req_ready, 1'b0);
    chk("magic_fail_cnt", fail_cnt, 2'd2);
    read_word("magic_err", 32'hEE00_0001);
    chk("magic_fail_after", fail_cnt, 2'd2);
    chk("magic_idle_ready", req_ready, 1'b1);

    grant_req("grant_clear");

    // Consumer stall on the second response word
    send_req("stall", 32'hA500_0002, K0, K1);
    read_word("stall_w0", 32'hD0D0_0001);
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_hold%0d_valid", i), rsp_valid, 1'b1);
      chk($sformatf("stall_hold%0d_data", i), data_out, 32'hD0D0_0002);
      step();
    end
    read_word("stall_w1", 32'hD0D0_0002);
    read_word("stall_w2", 32'hD0D0_0003);
    read_word("stall_w3", 32'hD0D0_0004);

    // Three consecutive key failures lead to lockout
    err_req("lk1", 32'hA500_0002, KBAD, 32'hEE00_0002, 2'd1);
    chk("lk1_no_lock", lock_active, 1'b0);
    err_req("lk2", 32'hA500_0002, KBAD, 32'hEE00_0002, 2'd2);
    chk("lk2_no_lock", lock_active, 1'b0);
    err_req("lk3", 32'hA500_0002, KBAD, 32'hEE00_0002, 2'd3);
    chk("lock_fail_clr", fail_cnt, 2'd0);
    data_in   = 32'hA500_0002;
    req_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("lock%0d_active", i), lock_active, 1'b1);
      chk($sformatf("lock%0d_ready", i), req_ready, 1'b0);
      step();
    end
    req_valid = 1'b0;
    chk("lock_end_active", lock_active, 1'b0);
    chk("lock_end_ready", req_ready, 1'b1);
    grant_req("post_lock");

    // Reset while the second key word is offered
    err_req("pre_rst", 32'hA500_0002, KBAD, 32'hEE00_0002, 2'd1);
    send_word("rk_hdr", 32'hA500_0002);
    send_word("rk_k0", K0);
    data_in   = K1;
    req_valid = 1'b1;
    rst       = 1'b0;
    #1;
    reset_outputs("rst_key");
    release_reset("rst_key");
    grant_req("after_rst_key");

    // Reset while the third response word is presented
    send_req("rr", 32'hA500_0002, K0, K1);
    read_word("rr_w0", 32'hD0D0_0001);
    read_word("rr_w1", 32'hD0D0_0002);
    chk("rr_w2_present", data_out, 32'hD0D0_0003);
    rst = 1'b0;
    #1;
    reset_outputs("rst_rsp");
    release_reset("rst_rsp");
    grant_req("after_rst_rsp");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
